fifo_read_stream_adapter: RTL and testbench

//   Read-domain stage directly downstream of async_fifo. Converts the FIFO's
//   p_read_en/p_read_empty pull interface into a valid/ready stream.

---
 rtl/fifo_read_stream_adapter.sv | 91 +++++++++
 tb/tb_fifo_read_stream_adapter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_stream_adapter.sv
// Pull-to-stream adapter behind async_fifo: prefetches into a DEPTH-entry ring; first word RD_LAT+1 cycles after issue.
// Backpressure: m_ready only stalls the ring; issue is credit-limited by registered count+inflight, never by m_ready.
module fifo_read_stream_adapter #(
  parameter int BITS   = 32,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic                       read_clk,
  input  logic                       read_rst,
  output logic                       p_read_en,
  input  logic [BITS-1:0]            p_read_data,
  input  logic                       p_read_empty,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [BITS-1:0]            m_data,
  output logic [$clog2(DEPTH+1)-1:0] m_level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + RD_LAT + 1);

  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     count_q, count_d;
  logic              valid_q;
  logic [BITS-1:0]   buf_q [DEPTH];
  logic [OW-1:0]     occupancy;
  logic              capture;
  logic              pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Words held plus words already requested: the credit that bounds issue.
  always_comb begin
    occupancy = OW'(count_q);
    for (int i = 0; i < RD_LAT; i++) begin
      occupancy = occupancy + OW'(rd_pipe_q[i]);
    end
  end

  assign p_read_en = !read_rst && !p_read_empty && (occupancy < OW'(DEPTH));
  assign capture   = rd_pipe_q[RD_LAT-1];
  assign pop       = valid_q && m_ready;

  always_comb begin
    rd_pipe_d = RD_LAT'({rd_pipe_q, p_read_en});
    wr_ptr_d  = capture ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    count_d   = count_q;
    case ({capture, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge read_clk or posedge read_rst) begin
    if (read_rst) begin
      rd_pipe_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      rd_pipe_q <= rd_pipe_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= (count_d != '0);
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge read_clk) begin
    if (capture) begin
      buf_q[wr_ptr_q] <= p_read_data;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = buf_q[rd_ptr_q];
  assign m_level = count_q;

  overflow_chk: assert property (@(posedge read_clk) disable iff (read_rst)
    !(capture && !pop && (count_q == LW'(DEPTH))));

endmodule

// File: tb/tb_fifo_read_stream_adapter.sv
// Bench: two adapters (RD_LAT=1 and RD_LAT=2, DEPTH=4) fed from queue-style FIFO models and checked every cycle.
module tb_fifo_read_stream_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             read_rst;
  logic             m_ready;
  bit               force_empty;
  bit               flush;
  logic [1:0]       en, vld, emp;
  logic [1:0][31:0] rdat, mdat;
  logic [1:0][2:0]  lvl;

  fifo_read_stream_adapter #(.BITS(32), .DEPTH(4), .RD_LAT(1)) u_dut0 (
    .read_clk(clk), .read_rst(read_rst), .p_read_en(en[0]), .p_read_data(rdat[0]),
    .p_read_empty(emp[0]), .m_valid(vld[0]), .m_ready(m_ready), .m_data(mdat[0]), .m_level(lvl[0]));

  fifo_read_stream_adapter #(.BITS(32), .DEPTH(4), .RD_LAT(2)) u_dut1 (
    .read_clk(clk), .read_rst(read_rst), .p_read_en(en[1]), .p_read_data(rdat[1]),
    .p_read_empty(emp[1]), .m_valid(vld[1]), .m_ready(m_ready), .m_data(mdat[1]), .m_level(lvl[1]));

  // Upstream FIFO contents, read latency line, and the expected output buffer.
  logic [31:0] src_mem [2][256];
  int          src_rd [2];
  int          src_wr [2];
  logic        dv  [2][4];
  logic [31:0] dly [2][4];
  logic [31:0] mb  [2][8];
  int          mb_hd  [2];
  int          mb_cnt [2];

  int          n_chk, n_fail;
  int          acc_idx [2];
  logic        prev_stall [2];
  logic [31:0] prev_dat [2];
  logic        s_en0, s_vld0;
  logic [31:0] s_dat0;
  int          s_lvl0;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int infl(input int i);
    int n = 0;
    for (int k = 0; k < lat(i); k++) if (dv[i][k]) n++;
    return n;
  endfunction

  function automatic logic exp_en(input int i);
    return !read_rst && !emp[i] && (mb_cnt[i] + infl(i) < 4);
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) emp[i] = force_empty || (src_rd[i] == src_wr[i]);
    rdat[0] = dly[0][0];
    rdat[1] = dly[1][1];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (read_rst) begin
        mb_hd[i]  <= 0;
        mb_cnt[i] <= 0;
        for (int k = 0; k < 4; k++) dv[i][k] <= 1'b0;
        if (flush) src_rd[i] <= src_wr[i];
      end else begin
        automatic logic e   = exp_en(i);
        automatic logic pop = (mb_cnt[i] != 0) && m_ready;
        automatic logic cap = dv[i][lat(i)-1];
        if (cap) mb[i][(mb_hd[i] + mb_cnt[i]) % 8] <= dly[i][lat(i)-1];
        mb_hd[i]  <= pop ? (mb_hd[i] + 1) % 8 : mb_hd[i];
        mb_cnt[i] <= mb_cnt[i] + int'(cap) - int'(pop);
        for (int k = 3; k > 0; k--) begin
          dv[i][k]  <= dv[i][k-1];
          dly[i][k] <= dly[i][k-1];
        end
        dv[i][0]  <= e;
        dly[i][0] <= e ? src_mem[i][src_rd[i]] : 32'hDEAD_BEEF;
        if (e) src_rd[i] <= src_rd[i] + 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      if (read_rst) begin
        chk("rst_en", 32'(en[i]), 0);
        chk("rst_valid", 32'(vld[i]), 0);
        chk("rst_level", 32'(lvl[i]), 0);
        acc_idx[i]    = src_rd[i];
        prev_stall[i] = 1'b0;
      end else begin
        chk("en", 32'(en[i]), 32'(exp_en(i)));
        chk("en_vs_empty", 32'(en[i] && emp[i]), 0);
        chk("valid", 32'(vld[i]), 32'(mb_cnt[i] != 0));
        chk("level", 32'(lvl[i]), 32'(mb_cnt[i]));
        chk("level_max", 32'(lvl[i] <= 3'd4), 1);
        if (mb_cnt[i] != 0) chk("data", mdat[i], mb[i][mb_hd[i]]);
        if (prev_stall[i]) begin
          chk("stall_valid", 32'(vld[i]), 1);
          chk("stall_data", mdat[i], prev_dat[i]);
        end
        if (vld[i] && m_ready) begin
          chk("order", mdat[i], src_mem[i][acc_idx[i]]);
          acc_idx[i]++;
        end
        prev_stall[i] = vld[i] && !m_ready;
        prev_dat[i]   = mdat[i];
      end
    end
    s_en0  = en[0];
    s_vld0 = vld[0];
    s_dat0 = mdat[0];
    s_lvl0 = int'(lvl[0]);
  endtask

  task automatic half_neg();
    @(negedge clk);
    compare();
  endtask

  task automatic half_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    half_neg();
    half_pos();
  endtask

  task automatic load(input logic [31:0] v);
    for (int i = 0; i < 2; i++) begin
      src_mem[i][src_wr[i]] = v;
      src_wr[i]++;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((acc_idx[0] != src_wr[0] || acc_idx[1] != src_wr[1]) && n < budget) begin
      cyc();
      n++;
    end
    chk("drained0", 32'(acc_idx[0]), 32'(src_wr[0]));
    chk("drained1", 32'(acc_idx[1]), 32'(src_wr[1]));
  endtask

  initial begin
    int pulses, fe, fv, got;
    logic [7:0] lf;
    read_rst    = 1'b1;
    m_ready     = 1'b0;
    force_empty = 1'b0;
    flush       = 1'b0;
    for (int i = 0; i < 2; i++) begin
      src_rd[i] = 0; src_wr[i] = 0; acc_idx[i] = 0; mb_hd[i] = 0; mb_cnt[i] = 0;
      prev_stall[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin dv[i][k] = 1'b0; dly[i][k] = '0; end
    end
    for (int k = 0; k < 6; k++) load(32'hA0 + 32'(k));

    // Reset held three cycles with a non-empty FIFO.
    repeat (3) cyc();
    read_rst = 1'b0;

    // Prefetch with the consumer stalled.
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      pulses += int'(s_en0);
      if (s_lvl0 == 4) chk("t2_hold", s_dat0, 32'hA0);
    end
    chk("t2_pulses", 32'(pulses), 4);
    chk("t2_level0", 32'(s_lvl0), 4);
    chk("t2_level1", 32'(lvl[1]), 4);
    chk("t2_head", s_dat0, 32'hA0);

    // Reset with the upstream flushed so streaming starts clean.
    read_rst = 1'b1; flush = 1'b1;
    cyc(); cyc();
    read_rst = 1'b0; flush = 1'b0;

    // Full-rate stream of 0..15.
    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) load(32'(k));
    fe = -1; fv = -1; got = 0;
    for (int n = 0; n < 40; n++) begin
      cyc();
      if (s_en0 && fe < 0) fe = n;
      if (s_vld0 && fv < 0) fv = n;
      if (fv >= 0 && got < 16) begin
        chk("t3_no_bubble", 32'(s_vld0), 1);
        chk("t3_seq", s_dat0, 32'(got));
        got++;
      end
    end
    chk("t3_latency", 32'(fv - fe), 2);
    chk("t3_count", 32'(got), 16);

    // Pseudo-random empty flag, 64 words.
    lf = 8'd7;
    for (int k = 0; k < 64; k++) load(32'h400 + 32'(k));
    for (int n = 0; n < 600 && (acc_idx[0] != src_wr[0] || acc_idx[1] != src_wr[1]); n++) begin
      lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      force_empty = lf[0];
      cyc();
    end
    force_empty = 1'b0;
    drain(50);

    // Random backpressure, 100 words.
    for (int k = 0; k < 100; k++) load(32'h500 + 32'(k));
    for (int n = 0; n < 1500 && (acc_idx[0] != src_wr[0] || acc_idx[1] != src_wr[1]); n++) begin
      m_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    m_ready = 1'b1;
    drain(50);

    // Reset while three words are buffered and one is in flight.
    m_ready = 1'b0;
    for (int k = 0; k < 8; k++) load(32'h600 + 32'(k));
    for (int n = 0; n < 20; n++) begin
      half_neg();
      if (s_lvl0 == 3) break;
      half_pos();
    end
    chk("t6_level3", 32'(s_lvl0), 3);
    chk("t6_inflight", 32'(infl(0)), 1);
    #1 read_rst = 1'b1;
    #1;
    chk("t6_valid0", 32'(vld[0]), 0);
    chk("t6_level0", 32'(lvl[0]), 0);
    chk("t6_valid1", 32'(vld[1]), 0);
    chk("t6_level1", 32'(lvl[1]), 0);
    half_pos();
    cyc();
    read_rst = 1'b0;
    m_ready  = 1'b1;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (s_vld0) begin
        chk("t6_first_word", s_dat0, 32'h604);
        got = 1;
        break;
      end
    end
    chk("t6_delivered", 32'(got), 1);
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
